// File: rtl/pfc_pkg.sv
// ----------------------------------------------------------------------------
// pfc_pkg
// Shared definitions for the parity frame checker: the FSM state encoding,
// the error-counter width and its saturation value.
// ----------------------------------------------------------------------------
package pfc_pkg;

   // Frame-checker FSM states
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2,
      ST_DONE   = 2'd3
   } pfc_state_e;

   // Error counter geometry
   localparam int unsigned ERR_CNT_W   = 8;
   localparam int unsigned ERR_CNT_MAX = 255;

endpackage : pfc_pkg

// File: rtl/parity_acc.sv
// ----------------------------------------------------------------------------
// parity_acc
// Running XOR accumulator and accepted-bit counter for one serial frame.
//
// Parameters
//   DATA_BITS  data bits per frame (2..255)
//   CNT_W      counter width, wide enough to hold DATA_BITS
//
// Ports
//   clk    in   rising-edge clock
//   rst_n  in   synchronous active-low reset
//   clr    in   clear accumulator and counter (frame start)
//   en     in   accept din this cycle
//   din    in   serial data bit
//   acc    out  XOR of all bits accepted since the last clear
//   cnt    out  number of bits accepted since the last clear
// ----------------------------------------------------------------------------
module parity_acc
   import pfc_pkg::*;
#(
   parameter int unsigned DATA_BITS = 8,
   parameter int unsigned CNT_W     = $clog2(DATA_BITS + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             en,
   input  logic             din,
   output logic             acc,
   output logic [CNT_W-1:0] cnt
);

   logic             r_acc;
   logic [CNT_W-1:0] r_cnt;

   // Clear has priority over accumulate so a new frame always starts clean
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_acc <= 1'b0;
         r_cnt <= '0;
      end else if (clr) begin
         r_acc <= 1'b0;
         r_cnt <= '0;
      end else if (en) begin
         r_acc <= r_acc ^ din;
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign acc = r_acc;
   assign cnt = r_cnt;

endmodule : parity_acc

// File: rtl/parity_frame_checker.sv
// ----------------------------------------------------------------------------
// parity_frame_checker
// Checks even parity of serial frames: DATA_BITS data bits followed by one
// parity bit, all qualified by din_valid. Reports the data XOR and a parity
// error flag for the last completed frame, with a one-cycle done pulse.
//
// Optional feature: define PFC_ERR_CNT_EN to add err_cnt, a saturating count
// of frames that failed parity. Without the macro the port and its register
// are absent.
//
// Parameters
//   DATA_BITS   data bits per frame (2..255)
//
// Ports
//   clk         in   rising-edge clock
//   rst_n       in   synchronous active-low reset
//   start       in   frame-start request, honoured only in IDLE
//   din         in   serial bit
//   din_valid   in   din qualifier, one bit consumed per high cycle
//   abort       in   drop current frame (DATA/PARITY only)
//   ready       out  high while idle
//   parity_out  out  XOR of last completed frame's data bits
//   err         out  last completed frame failed even parity
//   done        out  one-cycle completion pulse
//   err_cnt     out  saturating error count (PFC_ERR_CNT_EN only)
// ----------------------------------------------------------------------------
module parity_frame_checker
   import pfc_pkg::*;
#(
   parameter int unsigned DATA_BITS = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   input  logic din,
   input  logic din_valid,
   input  logic abort,
   output logic ready,
   output logic parity_out,
   output logic err,
   output logic done
`ifdef PFC_ERR_CNT_EN
   ,
   output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

   localparam int unsigned      CNT_W    = $clog2(DATA_BITS + 1);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_BITS - 1);

   pfc_state_e       r_state;
   pfc_state_e       w_state_next;
   logic             w_clr;
   logic             w_en;
   logic             w_load;
   logic             w_acc;
   logic [CNT_W-1:0] w_cnt;

   logic             r_ready;
   logic             r_done;
   logic             r_parity;
   logic             r_err;

   // Data accumulator and bit counter
   parity_acc #(
      .DATA_BITS (DATA_BITS),
      .CNT_W     (CNT_W)
   ) u_acc (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (w_clr),
      .en    (w_en),
      .din   (din),
      .acc   (w_acc),
      .cnt   (w_cnt)
   );

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state and datapath controls; abort outranks din_valid
   always_comb begin
      w_state_next = r_state;
      w_clr        = 1'b0;
      w_en         = 1'b0;
      w_load       = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_clr        = 1'b1;
               w_state_next = ST_DATA;
            end
         end
         ST_DATA: begin
            if (abort) begin
               w_state_next = ST_IDLE;
            end else if (din_valid) begin
               w_en = 1'b1;
               // Counter still holds the pre-increment count here
               if (w_cnt == LAST_IDX) begin
                  w_state_next = ST_PARITY;
               end
            end
         end
         ST_PARITY: begin
            if (abort) begin
               w_state_next = ST_IDLE;
            end else if (din_valid) begin
               w_load       = 1'b1;
               w_state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            w_state_next = ST_IDLE;
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // Status outputs decoded from the next state so they align with it
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_ready <= 1'b1;
         r_done  <= 1'b0;
      end else begin
         r_ready <= (w_state_next == ST_IDLE);
         r_done  <= (w_state_next == ST_DONE);
      end
   end

   // Frame result, updated only when the parity bit is accepted
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_parity <= 1'b0;
         r_err    <= 1'b0;
      end else if (w_load) begin
         r_parity <= w_acc;
         r_err    <= w_acc ^ din;
      end
   end

   assign ready      = r_ready;
   assign done       = r_done;
   assign parity_out = r_parity;
   assign err        = r_err;

`ifdef PFC_ERR_CNT_EN
   logic [ERR_CNT_W-1:0] r_err_cnt;

   // Counts failed frames during their DONE cycle, sticking at the maximum
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_err_cnt <= '0;
      end else if ((r_state == ST_DONE) && r_err &&
                   (r_err_cnt != ERR_CNT_W'(ERR_CNT_MAX))) begin
         r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
      end
   end

   assign err_cnt = r_err_cnt;
`endif

endmodule : parity_frame_checker

// File: tb/tb_parity_frame_checker.sv
// ----------------------------------------------------------------------------
// tb_parity_frame_checker
// Scoreboard bench for parity_frame_checker (DATA_BITS = 8). Inputs change
// on the falling edge; outputs are sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_parity_frame_checker;

   logic clk;
   logic rst_n;
   logic start;
   logic din;
   logic din_valid;
   logic abort;
   logic ready;
   logic parity_out;
   logic err;
   logic done;
`ifdef PFC_ERR_CNT_EN
   logic [7:0] err_cnt;
`endif

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   // Expected {parity_out, err} per completed frame
   logic [1:0] sb_q[$];

   logic       exp_parity = 1'b0;
   logic       exp_err    = 1'b0;
   int unsigned exp_cnt   = 0;

   parity_frame_checker #(.DATA_BITS(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .din        (din),
      .din_valid  (din_valid),
      .abort      (abort),
      .ready      (ready),
      .parity_out (parity_out),
      .err        (err),
      .done       (done)
`ifdef PFC_ERR_CNT_EN
      ,
      .err_cnt    (err_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   // Compare every done pulse against the oldest expected frame result
   always @(negedge clk) begin
      logic [1:0] e;
      if (rst_n === 1'b1 && done === 1'b1) begin
         if (sb_q.size() == 0) begin
            check("unexpected_done", done, 1'b0);
         end else begin
            e = sb_q.pop_front();
            check("parity_out", parity_out, e[1]);
            check("err", err, e[0]);
         end
      end
   end

   task automatic check_idle_outputs(input string tag);
      check({tag, "_ready"},  ready,      1'b1);
      check({tag, "_done"},   done,       1'b0);
      check({tag, "_parity"}, parity_out, exp_parity);
      check({tag, "_err"},    err,        exp_err);
`ifdef PFC_ERR_CNT_EN
      check({tag, "_err_cnt"}, err_cnt, exp_cnt);
`endif
   endtask

   // Called at a falling edge while IDLE; returns at the falling edge of the
   // first IDLE cycle after DONE so frames can run back to back.
   task automatic run_frame(input logic [7:0] data, input logic pbit,
                            input bit gaps, input bit mid_start);
      logic p;
      logic e;
      check("ready_idle", ready, 1'b1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("ready_busy", ready, 1'b0);
      for (int i = 0; i < 8; i++) begin
         if (gaps) begin
            din_valid = 1'b0;
            din       = 1'($urandom);
            @(negedge clk);
         end
         din_valid = 1'b1;
         din       = data[7-i];
         start     = mid_start && (i == 3);
         @(negedge clk);
      end
      start = 1'b0;
      if (gaps) begin
         din_valid = 1'b0;
         din       = 1'($urandom);
         @(negedge clk);
         check("done_early", done, 1'b0);
      end
      p = ^data;
      e = p ^ pbit;
      sb_q.push_back({p, e});
      din_valid = 1'b1;
      din       = pbit;
      @(negedge clk);
      din_valid = 1'b0;
      din       = 1'b0;
      check("done_latency", done, 1'b1);
      exp_parity = p;
      exp_err    = e;
      if (e && exp_cnt < 255) exp_cnt++;
      @(negedge clk);
      check_idle_outputs("after_done");
   endtask

   initial begin
      rst_n     = 1'b0;
      start     = 1'b0;
      din       = 1'b0;
      din_valid = 1'b0;
      abort     = 1'b0;
      repeat (2) @(negedge clk);
      check_idle_outputs("reset");
      rst_n = 1'b1;

      // Good frame, bad frame, then the good frame again with valid gaps
      run_frame(8'b1011_0001, 1'b0, 1'b0, 1'b0);
      run_frame(8'b1011_0011, 1'b0, 1'b0, 1'b0);
      run_frame(8'b1011_0001, 1'b0, 1'b1, 1'b0);

      // Abort after four data bits, colliding with a valid bit
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         din_valid = 1'b1;
         din       = 1'b1;
         @(negedge clk);
      end
      abort = 1'b1;
      @(negedge clk);
      abort     = 1'b0;
      din_valid = 1'b0;
      check_idle_outputs("abort_data");

      // Abort in IDLE does not block a start
      start = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      check("abort_idle_ignored", ready, 1'b0);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check_idle_outputs("abort_data2");
      run_frame(8'b0110_1000, 1'b0, 1'b0, 1'b0);

      // Abort in PARITY while the parity bit is offered
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         din_valid = 1'b1;
         din       = 1'b1;
         @(negedge clk);
      end
      abort     = 1'b1;
      din_valid = 1'b1;
      din       = 1'b1;
      @(negedge clk);
      abort     = 1'b0;
      din_valid = 1'b0;
      check_idle_outputs("abort_parity");

      // Start raised mid-DATA must not restart the frame
      run_frame(8'h80, 1'b1, 1'b0, 1'b1);

      // Reset during DATA after an error frame
      run_frame(8'b1011_0011, 1'b0, 1'b0, 1'b0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         din_valid = 1'b1;
         din       = 1'b1;
         @(negedge clk);
      end
      rst_n     = 1'b0;
      start     = 1'b1;
      din_valid = 1'b1;
      abort     = 1'b1;
      @(negedge clk);
      rst_n      = 1'b1;
      start      = 1'b0;
      din_valid  = 1'b0;
      abort      = 1'b0;
      exp_parity = 1'b0;
      exp_err    = 1'b0;
      exp_cnt    = 0;
      check_idle_outputs("mid_reset");
      @(negedge clk);
      check_idle_outputs("post_reset");

      // Random frames
      for (int k = 0; k < 6; k++) begin
         run_frame(8'($urandom), 1'($urandom), 1'($urandom), 1'b0);
      end

      // Long run of error frames drives the counter into saturation
      for (int k = 0; k < 260; k++) begin
         run_frame(8'b1011_0011, 1'b0, 1'b0, 1'b0);
      end
`ifdef PFC_ERR_CNT_EN
      check("err_cnt_saturated", err_cnt, 8'd255);
`endif

      repeat (2) @(negedge clk);
      check("scoreboard_empty", sb_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
      $fatal(1, "watchdog");
   end

endmodule : tb_parity_frame_checker
